// File: rtl/chip8_stack_param_if.sv
// Chip-8 return-address stack bus.
// CPU side drives ops, stack side returns data and status.
interface chip8_stack_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       op;
  logic [WIDTH-1:0] writedata;
  logic             clr_err;
  logic [WIDTH-1:0] outdata;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ack;
  logic             overflow;
  logic             underflow;

  modport master (
    output op, writedata, clr_err,
    input  outdata, count, full, empty,
    input  ack, overflow, underflow
  );

  modport slave (
    input  op, writedata, clr_err,
    output outdata, count, full, empty,
    output ack, overflow, underflow
  );
endinterface

// File: rtl/chip8_stack_param.sv
// Parametrised Chip-8 return-address stack.
// PUSH/POP/REPLACE with sticky errors and one-shot op qualification.
module chip8_stack_param #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter bit ONESHOT = 1'b1
) (
  input logic cpu_clk,
  input logic reset_n,
  chip8_stack_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic {ARMED, WAIT_REL} qual_e;

  qual_e state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic          full, empty, exec;
  logic          is_push, is_pop, is_repl;
  logic          we;
  logic [IW-1:0] top_idx, wr_idx;

  assign full    = (cnt_q == FULL_C);
  assign empty   = (cnt_q == '0);
  assign exec    = (state_q == ARMED) && (bus.op != OP_HOLD);
  assign is_push = (bus.op == OP_PUSH);
  assign is_pop  = (bus.op == OP_POP);
  assign is_repl = (bus.op == OP_REPL);
  assign top_idx = IW'(cnt_q - ONE_C);

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARMED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:    if (exec && ONESHOT) state_d = WAIT_REL;
      WAIT_REL: if (bus.op == OP_HOLD) state_d = ARMED;
      default:  state_d = ARMED;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    ack_d  = exec;
    ovf_d  = bus.clr_err ? 1'b0 : ovf_q;
    unf_d  = bus.clr_err ? 1'b0 : unf_q;
    we     = 1'b0;
    wr_idx = cnt_q[IW-1:0];
    if (exec) begin
      unique case (1'b1)
        is_push: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            cnt_d = cnt_q + ONE_C;
            out_d = bus.writedata;
          end
        end
        is_pop: begin
          if (empty) begin
            unf_d = 1'b1;
            out_d = '0;
          end else begin
            out_d = mem[top_idx];
            cnt_d = cnt_q - ONE_C;
          end
        end
        is_repl: begin
          if (empty) begin
            unf_d = 1'b1;
            out_d = '0;
          end else begin
            out_d  = mem[top_idx];
            we     = 1'b1;
            wr_idx = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      out_q <= '0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately unreset: entries above count are never read.
  always_ff @(posedge cpu_clk) begin
    if (we) mem[wr_idx] <= bus.writedata;
  end

  assign bus.outdata   = out_q;
  assign bus.count     = cnt_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ack       = ack_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
